fc_operand_feeder: RTL

- Operand source for the fully connected (FC) cell. Captures one hidden-state vector of hidden_size words and pulses start_cal to launch the cell.
- On each rd_weight_en request from the cell, fetches one weight from the external weight ROM and the matching hidden-state word, then presents both with a one-cycle fifo_ready.
- Request order: hidden index inner, output index outer, which matches the cell's accumulation order.

---
 rtl/fc_operand_feeder_if.sv | 27 ++
 rtl/fc_operand_feeder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fc_operand_feeder_if.sv
// Cell-side operand handshake and weight-ROM read bus of the FC operand feeder.
// The master modport is the feeder; the slave modport is the FC cell plus ROM.
interface fc_operand_feeder_if #(
  parameter int QZ   = 24,
  parameter int QZ_D = 8,
  parameter int WA_W = 16
);
  logic            start_cal;
  logic            rd_weight_en;
  logic            fifo_ready;
  logic            frame_done;
  logic [QZ-1:0]   ht_out;
  logic [QZ_D-1:0] weight_out;
  logic            wt_rd_en;
  logic [WA_W-1:0] wt_addr;
  logic [QZ_D-1:0] wt_data;

  modport master (
    output start_cal, fifo_ready, frame_done, ht_out, weight_out, wt_rd_en, wt_addr,
    input  rd_weight_en, wt_data
  );

  modport slave (
    input  start_cal, fifo_ready, frame_done, ht_out, weight_out, wt_rd_en, wt_addr,
    output rd_weight_en, wt_data
  );
endinterface

// File: rtl/fc_operand_feeder.sv
// Operand feeder for the FC cell: buffers one hidden-state vector, then serves
// (weight, hidden word) pairs on request, hidden index inner, output index outer.
module fc_operand_feeder #(
  parameter int QZ          = 24,
  parameter int QZ_D        = 8,
  parameter int output_size = 96,
  parameter int hidden_size = 512,
  parameter int RD_LAT      = 2,
  parameter int WA_W        = $clog2(output_size * hidden_size)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [QZ-1:0]       ht_in_data,
  input  logic                ht_in_valid,
  output logic                load_ready,
  output logic                busy,
  output logic                ovf_err,
  fc_operand_feeder_if.master op
);
  localparam int KW = (hidden_size > 1) ? $clog2(hidden_size) : 1;
  localparam int OW = (output_size > 1) ? $clog2(output_size) : 1;
  localparam int CW = $clog2(RD_LAT + 2);
  localparam logic [KW-1:0] K_LAST   = KW'(hidden_size - 1);
  localparam logic [OW-1:0] O_LAST   = OW'(output_size - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_LOAD, S_START, S_WAIT_REQ, S_FETCH, S_PRESENT, S_GUARD, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   lp_q, lp_d;
  logic [KW-1:0]   k_q, k_d;
  logic [OW-1:0]   o_q, o_d;
  logic [WA_W-1:0] wa_q, wa_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   rd_addr_q, rd_addr_d;
  logic [WA_W-1:0] wt_addr_q, wt_addr_d;
  logic [QZ-1:0]   ht_out_q, ht_out_d;
  logic [QZ_D-1:0] weight_out_q, weight_out_d;
  logic            ovf_err_q, ovf_err_d;
  logic [QZ-1:0]   buf_rd_q, buf_rd_d;
  logic            hbuf_we;
  logic [QZ-1:0]   hbuf [hidden_size];

  logic last_pair;
  assign last_pair = (k_q == K_LAST) && (o_q == O_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:     if (ht_in_valid && lp_q == K_LAST) state_d = S_START;
      S_START:    state_d = S_WAIT_REQ;
      S_WAIT_REQ: if (op.rd_weight_en) state_d = S_FETCH;
      S_FETCH:    if (cnt_q == CNT_LAST) state_d = S_PRESENT;
      S_PRESENT:  state_d = last_pair ? S_DONE : S_GUARD;
      S_GUARD:    state_d = S_WAIT_REQ;
      S_DONE:     state_d = S_LOAD;
      default:    state_d = S_LOAD;
    endcase
  end

  always_comb begin
    lp_d         = lp_q;
    k_d          = k_q;
    o_d          = o_q;
    wa_d         = wa_q;
    cnt_d        = cnt_q;
    rd_addr_d    = rd_addr_q;
    wt_addr_d    = wt_addr_q;
    ht_out_d     = ht_out_q;
    weight_out_d = weight_out_q;
    hbuf_we      = 1'b0;
    buf_rd_d     = hbuf[rd_addr_q];
    ovf_err_d    = ovf_err_q | (ht_in_valid && state_q != S_LOAD);
    case (state_q)
      S_LOAD: begin
        if (ht_in_valid) begin
          hbuf_we = 1'b1;
          lp_d    = (lp_q == K_LAST) ? '0 : lp_q + KW'(1);
        end
      end
      S_START: begin
        k_d  = '0;
        o_d  = '0;
        wa_d = '0;
      end
      S_WAIT_REQ: begin
        if (op.rd_weight_en) begin
          wt_addr_d = wa_q;
          rd_addr_d = k_q;
          cnt_d     = '0;
        end
      end
      S_FETCH: begin
        // Buffer word was read long before; both operands land together here.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          weight_out_d = op.wt_data;
          ht_out_d     = buf_rd_q;
        end
      end
      S_PRESENT: begin
        wa_d = wa_q + WA_W'(1);
        if (k_q == K_LAST) begin
          k_d = '0;
          o_d = (o_q == O_LAST) ? '0 : o_q + OW'(1);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lp_q         <= '0;
      k_q          <= '0;
      o_q          <= '0;
      wa_q         <= '0;
      cnt_q        <= '0;
      rd_addr_q    <= '0;
      wt_addr_q    <= '0;
      ht_out_q     <= '0;
      weight_out_q <= '0;
      ovf_err_q    <= 1'b0;
    end else begin
      lp_q         <= lp_d;
      k_q          <= k_d;
      o_q          <= o_d;
      wa_q         <= wa_d;
      cnt_q        <= cnt_d;
      rd_addr_q    <= rd_addr_d;
      wt_addr_q    <= wt_addr_d;
      ht_out_q     <= ht_out_d;
      weight_out_q <= weight_out_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  // Storage is left unreset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (hbuf_we) hbuf[lp_q] <= ht_in_data;
    buf_rd_q <= buf_rd_d;
  end

  always_comb begin
    load_ready    = (state_q == S_LOAD);
    busy          = (state_q != S_LOAD);
    op.start_cal  = (state_q == S_START);
    op.fifo_ready = (state_q == S_PRESENT);
    op.frame_done = (state_q == S_DONE);
    op.wt_rd_en   = (state_q == S_FETCH) && (cnt_q == '0);
  end

  assign op.wt_addr    = wt_addr_q;
  assign op.ht_out     = ht_out_q;
  assign op.weight_out = weight_out_q;
  assign ovf_err       = ovf_err_q;
endmodule
